mig_write_ctrl: RTL and testbench
=================================

# mig_write_ctrl

Drives the MIG user-interface write path from the 128-bit phrase stream produced by the pixel packer. Each accepted phrase is issued as one write command plus one write-data beat at a frame-relative DDR address. Frame-start tags from the stream realign the address counter. The block sits between the packer's output AXI-stream and the MIG `app_*` ports, in the MIG `ui_clk` domain.

## Interface
- `FRAME_PHRASES`, default 9600: phrases per frame (320×240×16 / 128); address index wraps here.
- `BASE_ADDR`, default 0: DDR address of frame phrase 0.
- `ADDR_STRIDE`, default 8: `app_addr` increment per phrase.
- `ADDR_WIDTH`, default 27: `app_addr` width.

Ports:
- `clk_in`  in  1  MIG ui_clk; the only clock.
- `rst_in`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  phrase valid.
- `ready_in`  out  1  phrase ready.
- `data_in`  in  128  phrase data.
- `tuser_in`  in  1  phrase holds first pixel of a frame.
- `app_addr`  out  ADDR_WIDTH  MIG command address.
- `app_cmd`  out  3  MIG command; constant 3'b000 (write).
- `app_en`  out  1  command strobe.
- `app_rdy`  in  1  MIG command accept.
- `app_wdf_data`  out  128  write data.
- `app_wdf_wren`  out  1  data strobe.
- `app_wdf_end`  out  1  equals `app_wdf_wren` (one beat per burst).
- `app_wdf_mask`  out  16  constant 0.
- `app_wdf_rdy`  in  1  MIG data accept.
- `frame_done`  out  1  one-cycle pulse when phrase index FRAME_PHRASES-1 is fully committed.
- `resync`  out  1  one-cycle pulse when `tuser_in` is accepted while the index is not 0.

## Operation
- One-entry holding register with `full`, `cmd_done`, `data_done` flags. States: EMPTY (`full`=0) and BUSY (`full`=1).
- Accept: `valid_in && ready_in`. On accept:
  - latch data into `app_wdf_data`;
  - latch `app_addr` = BASE_ADDR + idx·ADDR_STRIDE, where idx is 0 if `tuser_in`, else `next_idx`;
  - set `full`, clear both done flags.
- `next_idx` update: idx+1, wrapping to 0 when idx+1 == FRAME_PHRASES. Arithmetic is unsigned, truncated to ADDR_WIDTH.
- `app_en = full && !cmd_done`; `app_wdf_wren = full && !data_done`. The two channels are independent; either may complete first.
- `cmd_done` sets on `app_en && app_rdy`. `data_done` sets on `app_wdf_wren && app_wdf_rdy`.
- finish = `full` and each channel either already done or handshaking this cycle. finish clears `full` unless a new phrase is accepted on the same cycle.
- `ready_in = !rst_in && (!full || finish)`. This is a combinational path from `app_rdy`/`app_wdf_rdy` and gives back-to-back throughput.
- `frame_done` pulses the cycle after finish of a phrase latched with idx == FRAME_PHRASES-1.
- `resync` pulses the cycle after an accept with `tuser_in`=1 and `next_idx` != 0.
- `tuser_in`=1 with `next_idx`==0: normal, no `resync`.

## Timing
- Reset values: `app_en`=0, `app_wdf_wren`=0, `app_wdf_end`=0, `frame_done`=0, `resync`=0, `app_addr`=BASE_ADDR, `app_wdf_data`=0, `next_idx`=0, `full`=0. `ready_in` is 0 while `rst_in` is high and 1 on the first cycle after.
- Latency: a phrase accepted at edge N presents `app_en`/`app_wdf_wren` from cycle N+1.
- Throughput: 1 phrase/cycle while `app_rdy` and `app_wdf_rdy` are both held high.
- Strobes stay asserted, with `app_addr`/`app_wdf_data` stable, until their own handshake. A channel's strobe never reasserts after that channel's handshake for the same phrase.
- Stall: with `app_rdy`=0, the data beat may complete; `ready_in` stays 0 until the command handshakes.
- Reset mid-operation discards the held phrase; both strobes are 0 on the cycle after the reset edge.

## Test plan
- Reset, then 3 phrases with `tuser_in` on the first; `app_rdy`=`app_wdf_rdy`=1 -> addresses 0, 8, 16 on consecutive cycles; `ready_in` stays 1.
- `app_wdf_rdy`=1, `app_rdy`=0 for 5 cycles -> data beat taken in cycle 1; `app_wdf_wren` then drops; `app_en` holds with the same `app_addr`; `ready_in`=0 until `app_rdy` rises.
- FRAME_PHRASES=4, 6 phrases, no tuser -> addresses 0, 8, 16, 24, 0, 8; `frame_done` pulses once after the address-24 write commits.
- Tag `tuser_in` on the 3rd phrase -> that phrase goes to address 0; `resync` pulses once; subsequent address is 8.
- Random independent backpressure on `app_rdy`/`app_wdf_rdy` over 1000 phrases -> scoreboard shows every phrase with exactly one command and one data beat, in order, with correct addresses.
- Assert `rst_in` while BUSY with `app_rdy`=0 -> no strobes after the reset edge; `app_addr`=BASE_ADDR; the next frame starts at address 0.

Source files
------------

// File: rtl/mig_write_ctrl.sv
// MIG user-interface write path: takes 128-bit phrases from the pixel packer and issues
// one write command plus one write-data beat per phrase at a frame-relative DDR address.
module mig_write_ctrl #(
   parameter int FRAME_PHRASES = 9600,
   parameter int BASE_ADDR     = 0,
   parameter int ADDR_STRIDE   = 8,
   parameter int ADDR_WIDTH    = 27
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  valid_in,
   output logic                  ready_in,
   input  logic [127:0]          data_in,
   input  logic                  tuser_in,
   output logic [ADDR_WIDTH-1:0] app_addr,
   output logic [2:0]            app_cmd,
   output logic                  app_en,
   input  logic                  app_rdy,
   output logic [127:0]          app_wdf_data,
   output logic                  app_wdf_wren,
   output logic                  app_wdf_end,
   output logic [15:0]           app_wdf_mask,
   input  logic                  app_wdf_rdy,
   output logic                  frame_done,
   output logic                  resync
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_PHRASES - 1);

   typedef enum logic {EMPTY, BUSY} state_t;

   state_t                  state;
   logic                    cmd_done;
   logic                    data_done;
   logic                    last_held;
   logic [ADDR_WIDTH-1:0]   next_idx;
   logic [ADDR_WIDTH-1:0]   use_idx;
   logic                    full;
   logic                    cmd_hs;
   logic                    data_hs;
   logic                    finish;
   logic                    accept;

   function automatic logic [ADDR_WIDTH-1:0] phrase_addr(input logic [ADDR_WIDTH-1:0] idx);
      return ADDR_WIDTH'(BASE_ADDR) + idx * ADDR_WIDTH'(ADDR_STRIDE);
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] idx_after(input logic [ADDR_WIDTH-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + ADDR_WIDTH'(1);
   endfunction

   assign full         = (state == BUSY);
   assign app_en       = full && !cmd_done;
   assign app_wdf_wren = full && !data_done;
   assign app_wdf_end  = app_wdf_wren;
   assign app_cmd      = 3'b000;
   assign app_wdf_mask = '0;

   assign cmd_hs  = app_en && app_rdy;
   assign data_hs = app_wdf_wren && app_wdf_rdy;
   // Holding slot frees up in the same cycle its last outstanding channel handshakes.
   assign finish  = full && (cmd_done || app_rdy) && (data_done || app_wdf_rdy);
   assign ready_in = !rst_in && (!full || finish);
   assign accept   = valid_in && ready_in;
   assign use_idx  = tuser_in ? '0 : next_idx;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state        <= EMPTY;
         cmd_done     <= 1'b0;
         data_done    <= 1'b0;
         last_held    <= 1'b0;
         next_idx     <= '0;
         app_addr     <= ADDR_WIDTH'(BASE_ADDR);
         app_wdf_data <= '0;
         frame_done   <= 1'b0;
         resync       <= 1'b0;
      end else begin
         frame_done <= finish && last_held;
         resync     <= accept && tuser_in && (next_idx != '0);
         if (accept) begin
            state        <= BUSY;
            cmd_done     <= 1'b0;
            data_done    <= 1'b0;
            app_addr     <= phrase_addr(use_idx);
            app_wdf_data <= data_in;
            next_idx     <= idx_after(use_idx);
            last_held    <= (use_idx == LAST_IDX);
         end else begin
            if (finish) state <= EMPTY;
            if (cmd_hs) cmd_done <= 1'b1;
            if (data_hs) data_done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mig_write_ctrl.sv
// Randomized bench for mig_write_ctrl: a count-based scoreboard of accepted phrases,
// command handshakes and data handshakes predicts every strobe, address and pulse.
module tb_mig_write_ctrl;

   localparam int FP     = 4;
   localparam int BASE   = 64;
   localparam int STRIDE = 8;
   localparam int AW     = 27;

   logic          clk = 1'b0;
   logic          rst_in = 1'b1;
   logic          valid_in = 1'b0;
   logic          tuser_in = 1'b0;
   logic          app_rdy = 1'b0;
   logic          app_wdf_rdy = 1'b0;
   logic [127:0]  data_in = '0;
   logic          ready_in;
   logic [AW-1:0] app_addr;
   logic [2:0]    app_cmd;
   logic          app_en;
   logic [127:0]  app_wdf_data;
   logic          app_wdf_wren;
   logic          app_wdf_end;
   logic [15:0]   app_wdf_mask;
   logic          frame_done;
   logic          resync;

   mig_write_ctrl #(
      .FRAME_PHRASES(FP), .BASE_ADDR(BASE), .ADDR_STRIDE(STRIDE), .ADDR_WIDTH(AW)
   ) dut (
      .clk_in(clk), .rst_in(rst_in), .valid_in(valid_in), .ready_in(ready_in),
      .data_in(data_in), .tuser_in(tuser_in), .app_addr(app_addr), .app_cmd(app_cmd),
      .app_en(app_en), .app_rdy(app_rdy), .app_wdf_data(app_wdf_data),
      .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask),
      .app_wdf_rdy(app_wdf_rdy), .frame_done(frame_done), .resync(resync)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Scoreboard: phrases accepted, commands taken, data beats taken since last reset.
   int            acc_n = 0;
   int            cmd_n = 0;
   int            dat_n = 0;
   int            nidx = 0;
   bit            exp_fd = 1'b0;
   bit            exp_rs = 1'b0;
   bit            post_rst = 1'b0;
   logic [AW-1:0] exp_addr [4096];
   logic [127:0]  exp_data [4096];
   int            exp_idx  [4096];

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic cycle(input bit r, input bit v, input bit t, input bit cr, input bit dr,
                        input logic [127:0] d);
      bit hs_c, hs_d, acc, rdy_exp;
      int idx, old_min, new_min;
      @(negedge clk);
      rst_in      = r;
      valid_in    = v;
      tuser_in    = t;
      app_rdy     = r ? 1'b0 : cr;
      app_wdf_rdy = r ? 1'b0 : dr;
      data_in     = d;
      #1;
      if (r) begin
         check_val("ready_in_in_reset", ready_in, 0);
         acc_n = 0; cmd_n = 0; dat_n = 0; nidx = 0;
         exp_fd = 1'b0; exp_rs = 1'b0; post_rst = 1'b1;
      end else begin
         if (post_rst) begin
            check_val("reset_app_addr", app_addr, BASE);
            check_val("reset_wdf_data", app_wdf_data, 0);
            check_val("app_cmd", app_cmd, 0);
            check_val("app_wdf_mask", app_wdf_mask, 0);
            post_rst = 1'b0;
         end
         check_val("app_en", app_en, acc_n > cmd_n);
         check_val("app_wdf_wren", app_wdf_wren, acc_n > dat_n);
         check_val("app_wdf_end", app_wdf_end, acc_n > dat_n);
         if (acc_n > cmd_n) check_val("app_addr", app_addr, exp_addr[cmd_n]);
         if (acc_n > dat_n) check_val("app_wdf_data", app_wdf_data, exp_data[dat_n]);
         check_val("frame_done", frame_done, exp_fd);
         check_val("resync", resync, exp_rs);

         hs_c    = (acc_n > cmd_n) && cr;
         hs_d    = (acc_n > dat_n) && dr;
         rdy_exp = (cmd_n + int'(hs_c) == acc_n) && (dat_n + int'(hs_d) == acc_n);
         check_val("ready_in", ready_in, rdy_exp);
         acc = v && rdy_exp;

         old_min = (cmd_n < dat_n) ? cmd_n : dat_n;
         cmd_n += int'(hs_c);
         dat_n += int'(hs_d);
         new_min = (cmd_n < dat_n) ? cmd_n : dat_n;
         exp_fd = (new_min > old_min) && (exp_idx[old_min] == FP - 1);
         exp_rs = acc && t && (nidx != 0);
         if (acc) begin
            idx = t ? 0 : nidx;
            exp_addr[acc_n] = AW'(BASE + idx * STRIDE);
            exp_data[acc_n] = d;
            exp_idx[acc_n]  = idx;
            acc_n++;
            nidx = (idx + 1) % FP;
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((cmd_n < acc_n || dat_n < acc_n) && n < 50) begin
         cycle(0, 0, 0, 1, 1, '0);
         n++;
      end
      check_val("drain_complete", (cmd_n == acc_n) && (dat_n == acc_n), 1);
      repeat (2) cycle(0, 0, 0, 1, 1, '0);
   endtask

   initial begin
      int start, n;
      logic [127:0] d;

      repeat (2) cycle(1, 0, 0, 0, 0, '0);

      for (int i = 0; i < 3; i++) cycle(0, 1, i == 0, 1, 1, rand128());
      drain();

      // Command channel stalled while the data beat goes through.
      cycle(0, 1, 0, 1, 1, rand128());
      d = rand128();
      repeat (5) cycle(0, 1, 0, 0, 1, d);
      cycle(0, 1, 0, 1, 1, d);
      drain();

      // Wrap across the frame boundary from a fresh reset.
      cycle(1, 0, 0, 0, 0, '0);
      for (int i = 0; i < 6; i++) cycle(0, 1, 0, 1, 1, rand128());
      drain();

      // Frame-start tag mid-frame realigns the index.
      cycle(1, 0, 0, 0, 0, '0);
      for (int i = 0; i < 5; i++) cycle(0, 1, i == 2, 1, 1, rand128());
      drain();

      // Random traffic with independent backpressure on both channels.
      start = acc_n;
      n = 0;
      while ((acc_n - start) < 1000 && n < 20000) begin
         cycle(0, ($urandom % 4) != 0, ($urandom % 64) == 0,
               ($urandom % 3) != 0, ($urandom % 3) != 0, rand128());
         n++;
      end
      check_val("random_phrases_done", (acc_n - start) >= 1000, 1);
      drain();

      // Reset while holding a phrase whose command is stalled.
      cycle(0, 1, 0, 0, 0, rand128());
      cycle(0, 0, 0, 0, 1, '0);
      cycle(0, 0, 0, 0, 0, '0);
      cycle(1, 0, 0, 0, 0, '0);
      cycle(0, 0, 0, 0, 0, '0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1, 1, rand128());
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
